// File: rtl/hyper_trap_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hyper_trap_ctrl_if                                              |
// | Purpose  : CPU-side bus bundle for the hypervisor register window.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface hyper_trap_ctrl_if;
    logic       hyper_cs;
    logic [7:0] hyper_addr;
    logic [7:0] hyper_io_data_i;
    logic [7:0] hyper_data_o;
    logic       cpu_write;
    logic       ready;
    logic       phase3;
    logic       hyper_mode;
    logic       hyp;
    logic       load_user_reg;
    logic [7:0] user_mapper_reg;

    modport master (
        output hyper_cs, hyper_addr, hyper_io_data_i, cpu_write, ready,
               phase3, hyper_mode, user_mapper_reg,
        input  hyper_data_o, hyp, load_user_reg
    );

    modport slave (
        input  hyper_cs, hyper_addr, hyper_io_data_i, cpu_write, ready,
               phase3, hyper_mode, user_mapper_reg,
        output hyper_data_o, hyp, load_user_reg
    );
endinterface
`default_nettype wire

// File: rtl/hyper_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hyper_trap_ctrl                                                 |
// | Purpose  : $D640-$D67F hypervisor window: trap entry/exit, trap info,      |
// |            user-context access strobe and scratch bytes.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module hyper_trap_ctrl (
    input  logic              clk,
    input  logic              reset,
    hyper_trap_ctrl_if.slave  bus
);

    localparam logic [5:0] C_OFF_TRAPNUM  = 6'h10;
    localparam logic [5:0] C_OFF_TRAPDATA = 6'h11;
    localparam logic [5:0] C_OFF_SCR_LO   = 6'h12;
    localparam logic [5:0] C_OFF_EXIT     = 6'h3F;
    localparam int         C_SCR_BYTES    = 45;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRAP = 2'd1,
        S_EXIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_hyp;
    logic [7:0]  r_data_o;
    logic [7:0]  r_trapnum;
    logic [7:0]  r_trapdata;
    logic [7:0]  r_scratch [0:C_SCR_BYTES-1];

    logic [5:0]  w_off;
    logic        w_wr;
    logic        w_ctx;
    logic        w_scr;
    logic        w_pending;
    logic [5:0]  w_scr_idx;
    logic [7:0]  w_rdata;
    logic        w_unused_addr;

    assign w_off         = bus.hyper_addr[5:0];
    assign w_unused_addr = &{1'b0, bus.hyper_addr[7:6]};
    assign w_wr          = bus.hyper_cs & bus.cpu_write & bus.ready & bus.phase3;
    assign w_ctx         = (w_off[5:4] == 2'b00);
    assign w_scr         = (w_off >= C_OFF_SCR_LO) && (w_off != C_OFF_EXIT);
    assign w_scr_idx     = w_off - C_OFF_SCR_LO;
    assign w_pending     = (r_state != S_IDLE);

    // Unregistered so the CPU latches the user-context byte on the same edge.
    assign bus.load_user_reg = reset & w_wr & bus.hyper_mode & w_ctx;
    assign bus.hyp           = r_hyp;
    assign bus.hyper_data_o  = r_data_o;

    always_comb begin
        w_rdata = 8'h00;
        if (!bus.hyper_mode) begin
            w_rdata = 8'hFF;
        end else if (w_ctx) begin
            w_rdata = bus.user_mapper_reg;
        end else if (w_off == C_OFF_TRAPNUM) begin
            w_rdata = r_trapnum;
        end else if (w_off == C_OFF_TRAPDATA) begin
            w_rdata = r_trapdata;
        end else if (w_scr) begin
            w_rdata = r_scratch[w_scr_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_hyp      <= 1'b0;
            r_data_o   <= 8'h00;
            r_trapnum  <= 8'h00;
            r_trapdata <= 8'h00;
            for (int i = 0; i < C_SCR_BYTES; i++) begin
                r_scratch[i] <= 8'h00;
            end
        end else begin
            if (bus.hyper_cs) begin
                r_data_o <= w_rdata;
            end

            // Each pending request is acknowledged by the CPU flipping mode.
            case (r_state)
                S_IDLE: begin
                    if (w_wr && !bus.hyper_mode) begin
                        r_state    <= S_TRAP;
                        r_hyp      <= 1'b1;
                        r_trapnum  <= {2'b00, w_off};
                        r_trapdata <= bus.hyper_io_data_i;
                    end else if (w_wr && (w_off == C_OFF_EXIT)) begin
                        r_state <= S_EXIT;
                        r_hyp   <= 1'b1;
                    end
                end
                S_TRAP: begin
                    if (bus.hyper_mode) begin
                        r_state <= S_IDLE;
                        r_hyp   <= 1'b0;
                    end
                end
                S_EXIT: begin
                    if (!bus.hyper_mode) begin
                        r_state <= S_IDLE;
                        r_hyp   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hyp   <= 1'b0;
                end
            endcase

            if (w_wr && bus.hyper_mode) begin
                if (!w_pending && (w_off == C_OFF_TRAPNUM)) begin
                    r_trapnum <= bus.hyper_io_data_i;
                end
                if (!w_pending && (w_off == C_OFF_TRAPDATA)) begin
                    r_trapdata <= bus.hyper_io_data_i;
                end
                if (w_scr) begin
                    r_scratch[w_scr_idx] <= bus.hyper_io_data_i;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hyper_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hyper_trap_ctrl                                              |
// | Purpose  : Directed + randomized check of hyper_trap_ctrl against a model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_hyper_trap_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    hyper_trap_ctrl_if bus ();

    hyper_trap_ctrl u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: the window as a 64-byte array plus a pending flag and the
    // mode in which that request was raised.
    logic [7:0] m_reg [0:63];
    logic       m_hyp    = 1'b0;
    logic       m_hyp_hv = 1'b0;
    logic [7:0] m_rd     = 8'h00;

    logic [5:0] t_off;
    logic       t_wr;
    assign t_off = bus.hyper_addr[5:0];
    assign t_wr  = bus.hyper_cs & bus.cpu_write & bus.ready & bus.phase3;

    function automatic logic [7:0] model_read(input logic mode, input logic [5:0] off,
                                              input logic [7:0] umr);
        if (!mode)       return 8'hFF;
        if (off < 6'd16) return umr;
        if (off == 6'd63) return 8'h00;
        return m_reg[off];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hyp    <= 1'b0;
            m_hyp_hv <= 1'b0;
            m_rd     <= 8'h00;
            for (int i = 0; i < 64; i++) m_reg[i] <= 8'h00;
        end else begin
            if (bus.hyper_cs)
                m_rd <= model_read(bus.hyper_mode, t_off, bus.user_mapper_reg);
            if (m_hyp) begin
                if (bus.hyper_mode != m_hyp_hv) m_hyp <= 1'b0;
            end else if (t_wr && (!bus.hyper_mode || t_off == 6'd63)) begin
                m_hyp    <= 1'b1;
                m_hyp_hv <= bus.hyper_mode;
                if (!bus.hyper_mode) begin
                    m_reg[16] <= {2'b00, t_off};
                    m_reg[17] <= bus.hyper_io_data_i;
                end
            end
            if (t_wr && bus.hyper_mode && t_off >= 6'd16 && t_off <= 6'd62
                && (t_off >= 6'd18 || !m_hyp))
                m_reg[t_off] <= bus.hyper_io_data_i;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_load;
        exp_load = rst_n & t_wr & bus.hyper_mode & (t_off < 6'd16);
        chk("model_hyp",  {7'd0, bus.hyp}, {7'd0, m_hyp});
        chk("model_rd",   bus.hyper_data_o, m_rd);
        chk("model_load", {7'd0, bus.load_user_reg}, {7'd0, exp_load});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic drv(input logic cs, input logic [7:0] addr, input logic [7:0] data,
                       input logic w, input logic rdy, input logic ph, input logic mode,
                       input logic [7:0] umr);
        bus.hyper_cs        = cs;
        bus.hyper_addr      = addr;
        bus.hyper_io_data_i = data;
        bus.cpu_write       = w;
        bus.ready           = rdy;
        bus.phase3          = ph;
        bus.hyper_mode      = mode;
        bus.user_mapper_reg = umr;
    endtask

    initial begin
        logic       mode;
        logic [5:0] off;
        drv(1'b1, 8'h42, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        @(posedge clk);
        tick();
        chk("reset_hyp",  {7'd0, bus.hyp}, 8'h00);
        chk("reset_data", bus.hyper_data_o, 8'h00);
        chk("reset_load", {7'd0, bus.load_user_reg}, 8'h00);

        drv(1'b1, 8'h50, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("reset_trapnum", bus.hyper_data_o, 8'h00);

        // Trap entry from user mode, second write must not overwrite.
        drv(1'b1, 8'h45, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        chk("trap_hyp_set", {7'd0, bus.hyp}, 8'h01);
        drv(1'b1, 8'h47, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        chk("trap_hyp_hold", {7'd0, bus.hyp}, 8'h01);
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("trap_hyp_ack", {7'd0, bus.hyp}, 8'h00);
        drv(1'b1, 8'h50, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("trapnum", bus.hyper_data_o, 8'h05);
        drv(1'b1, 8'h51, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("trapdata", bus.hyper_data_o, 8'h5A);

        // Gated writes in user mode.
        drv(1'b1, 8'h45, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk("gate_ready", {7'd0, bus.hyp}, 8'h00);
        drv(1'b1, 8'h46, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        chk("gate_phase3", {7'd0, bus.hyp}, 8'h00);
        drv(1'b0, 8'h46, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        chk("gate_cs", {7'd0, bus.hyp}, 8'h00);
        drv(1'b1, 8'h50, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("gate_trapnum", bus.hyper_data_o, 8'h05);

        // Scratch byte.
        drv(1'b1, 8'h60, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        drv(1'b1, 8'h60, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("scratch_rd", bus.hyper_data_o, 8'hA5);
        drv(1'b1, 8'h60, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        chk("scratch_user_rd", bus.hyper_data_o, 8'hFF);

        // User-context strobe and read-through.
        drv(1'b1, 8'h42, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        #1 chk("ctx_load_hi", {7'd0, bus.load_user_reg}, 8'h01);
        tick();
        drv(1'b1, 8'h42, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
        #1 chk("ctx_load_lo", {7'd0, bus.load_user_reg}, 8'h00);
        tick();
        chk("ctx_read", bus.hyper_data_o, 8'h77);

        // Exit request and return.
        drv(1'b1, 8'h7F, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("exit_set", {7'd0, bus.hyp}, 8'h01);
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("exit_hold", {7'd0, bus.hyp}, 8'h01);
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        tick();
        chk("exit_ack", {7'd0, bus.hyp}, 8'h00);

        // Reset while a request is pending.
        drv(1'b1, 8'h7F, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("rst_pre_hyp", {7'd0, bus.hyp}, 8'h01);
        drv(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        rst_n = 1'b0;
        #1 chk("rst_async_hyp", {7'd0, bus.hyp}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 8'h50, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        tick();
        chk("rst_trapnum", bus.hyper_data_o, 8'h00);

        // Randomized traffic.
        mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) mode = ~mode;
            case ($urandom_range(5))
                0:       off = 6'h10;
                1:       off = 6'h11;
                2:       off = 6'h3F;
                3:       off = 6'($urandom_range(18, 24));
                default: off = 6'($urandom);
            endcase
            drv($urandom_range(4) != 0, {2'($urandom), off}, 8'($urandom),
                $urandom_range(1) == 1, $urandom_range(6) != 0,
                $urandom_range(6) != 0, mode, 8'($urandom));
            rst_n = ($urandom_range(299) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
